// File: rtl/ov_dvp_gen.sv
// ov_dvp_gen: OV-style DVP sensor emulator driving test patterns.
// Optional CRC of active bytes: define OV_DVP_GEN_CRC_EN.
//
// Ports:
//   clk_sys, rst_n        system clock, async active-low reset
//   enable                frames generated while high
//   pattern_sel[1:0]      0 col ramp, 1 55/AA, 2 line index, 3 PRBS8
//   dvp_pclk/vsync/href   generated DVP framing
//   dvp_data[7:0]         pixel byte, 0 outside href
//   busy                  state is not IDLE
//   frame_done            1-cycle pulse at end of frame
//   frame_cnt[15:0]       completed frames (wraps)
//   frame_crc[15:0]       CRC-16/CCITT of last frame, 0 if disabled
module ov_dvp_gen #(
    parameter int PCLK_DIV = 4,
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 144,
    parameter int V_ACTIVE = 480,
    parameter int VSYNC_W  = 3,
    parameter int V_BP     = 17,
    parameter int V_FP     = 10
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        dvp_pclk,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [15:0] frame_crc
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int PW = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;
    localparam int CW = $clog2(H_TOTAL);
    localparam int LMAX =
        max2(max2(VSYNC_W, V_BP), max2(V_ACTIVE, V_FP));
    localparam int LW = $clog2(LMAX + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(PCLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(PCLK_DIV / 2);
    localparam logic [CW-1:0] COL_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
    localparam logic [LW-1:0] VS_L = LW'(VSYNC_W - 1);
    localparam logic [LW-1:0] BP_L = LW'((V_BP > 0) ? V_BP - 1 : 0);
    localparam logic [LW-1:0] AC_L = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] FP_L = LW'(V_FP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP
    } state_t;

    state_t        state, n_state;
    logic [PW-1:0] phase, ph_nx;
    logic [CW-1:0] col, n_col;
    logic [LW-1:0] line, n_line, lim;
    logic [1:0]    sel_q;
    logic [7:0]    prbs, prbs_nx, pat, data_n;
    logic          tick, col_end, line_end;
    logic          frame_end, start, n_href;

    assign tick  = (phase == PH_LAST);
    assign ph_nx = tick ? '0 : phase + 1'b1;
    assign busy  = (state != S_IDLE);
    assign prbs_nx =
        {prbs[6:0], prbs[7] ^ prbs[5] ^ prbs[4] ^ prbs[3]};

    // Position (state/col/line) that the next tick moves to;
    // framing outputs are registered from this next position.
    always_comb begin
        n_state = state;
        n_col   = col;
        n_line  = line;
        unique case (state)
            S_VSYNC:  lim = VS_L;
            S_VBP:    lim = BP_L;
            S_ACTIVE: lim = AC_L;
            default:  lim = FP_L;
        endcase
        col_end   = (col == COL_LAST);
        line_end  = (line == lim);
        frame_end = (state == S_VFP) && col_end && line_end;
        if (state == S_IDLE) begin
            if (enable) begin
                n_state = S_VSYNC;
                n_col   = '0;
                n_line  = '0;
            end
        end else if (!col_end) begin
            n_col = col + 1'b1;
        end else begin
            n_col = '0;
            if (!line_end) begin
                n_line = line + 1'b1;
            end else begin
                n_line = '0;
                unique case (state)
                    S_VSYNC:  n_state = (V_BP > 0) ? S_VBP : S_ACTIVE;
                    S_VBP:    n_state = S_ACTIVE;
                    S_ACTIVE: n_state = S_VFP;
                    S_VFP:    n_state = enable ? S_VSYNC : S_IDLE;
                    default:  n_state = S_IDLE;
                endcase
            end
        end
        start  = (n_state == S_VSYNC) && (state != S_VSYNC);
        n_href = (n_state == S_ACTIVE) && (n_col < HA);
        unique case (sel_q)
            2'd0: pat = 8'(n_col);
            2'd1: pat = n_col[0] ? 8'hAA : 8'h55;
            2'd2: pat = 8'(n_line);
            2'd3: pat = prbs;
        endcase
        data_n = n_href ? pat : 8'h00;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            dvp_pclk   <= 1'b0;
            state      <= S_IDLE;
            col        <= '0;
            line       <= '0;
            sel_q      <= 2'd0;
            prbs       <= 8'hFF;
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            phase      <= ph_nx;
            dvp_pclk   <= (ph_nx >= PH_HALF);
            frame_done <= 1'b0;
            if (tick) begin
                state     <= n_state;
                col       <= n_col;
                line      <= n_line;
                dvp_vsync <= (n_state == S_VSYNC);
                dvp_href  <= n_href;
                dvp_data  <= data_n;
                if (start) begin
                    sel_q <= pattern_sel;
                    prbs  <= 8'hFF;
                end else if (n_href) begin
                    prbs <= prbs_nx;
                end
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                end
            end
        end
    end

`ifdef OV_DVP_GEN_CRC_EN
    function automatic logic [15:0] crc_byte(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    logic [15:0] crc;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else if (tick) begin
            if (start) begin
                crc <= 16'hFFFF;
            end else if (n_href) begin
                crc <= crc_byte(crc, data_n);
            end
            if (frame_end) begin
                frame_crc <= crc;
            end
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ov_dvp_gen.sv
// tb_ov_dvp_gen: directed bench for ov_dvp_gen.
// Small frame: 48 clk_sys per line, 240 per frame.
module tb_ov_dvp_gen;
    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        dvp_pclk;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [15:0] frame_crc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    ov_dvp_gen #(
        .PCLK_DIV(4), .H_ACTIVE(8), .H_BLANK(4),
        .V_ACTIVE(2), .VSYNC_W(1), .V_BP(1), .V_FP(1)
    ) dut (
        .clk_sys(clk_sys),
        .rst_n(rst_n),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .dvp_pclk(dvp_pclk),
        .dvp_vsync(dvp_vsync),
        .dvp_href(dvp_href),
        .dvp_data(dvp_data),
        .busy(busy),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .frame_crc(frame_crc)
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return dvp_vsync;
            1:       return dvp_href;
            default: return frame_done;
        endcase
    endfunction

    // Cycles spent with the chosen signal at lvl (bounded).
    task automatic run_len(
        input int which, input logic lvl, output int n
    );
        n = 0;
        while (sig(which) === lvl && n < 2000) begin
            n++;
            step();
        end
    endtask

`ifdef OV_DVP_GEN_CRC_EN
    function automatic logic [15:0] crc16(
        input logic [15:0] c, input logic [7:0] d
    );
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction
`endif

    task automatic test_reset();
        logic ep [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic ev [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [44:0] all_out;
        rst_n = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'd0;
        repeat (3) step();
        all_out = {dvp_pclk, dvp_vsync, dvp_href, dvp_data, busy,
                   frame_done, frame_cnt, frame_crc};
        n_cmp++;
        if (all_out !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (dvp_pclk !== ep[i] || dvp_vsync !== ev[i]) begin
                n_bad++;
                $display("FAIL reset_release[%0d]: pclk/vsync %b%b want %b%b",
                         i, dvp_pclk, dvp_vsync, ep[i], ev[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_start: got %b want 1", busy);
        end
    endtask

    task automatic test_framing();
        int n;
        int want [6] = '{48, 48, 32, 16, 32, 64};
        int got  [6];
        run_len(0, 1'b1, got[0]);
        run_len(1, 1'b0, got[1]);
        run_len(1, 1'b1, got[2]);
        run_len(1, 1'b0, got[3]);
        run_len(1, 1'b1, got[4]);
        run_len(2, 1'b0, got[5]);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (got[i] !== want[i]) begin
                n_bad++;
                $display("FAIL framing_len[%0d]: got %0d want %0d",
                         i, got[i], want[i]);
            end
        end
        n_cmp++;
        if (frame_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL frame_cnt_1: got %h want 0001", frame_cnt);
        end
        run_len(2, 1'b1, n);
        n_cmp++;
        if (n !== 1) begin
            n_bad++;
            $display("FAIL done_width: got %0d want 1", n);
        end
        run_len(2, 1'b0, n);
        n_cmp++;
        if (n !== 239 || frame_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL frame_period: got %0d cnt %h want 239 cnt 0002",
                     n, frame_cnt);
        end
    endtask

    task automatic test_data(input logic [1:0] p);
        logic [7:0] prbs_tab [16] = '{
            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1, 8'hC2, 8'h85,
            8'h0B, 8'h17, 8'h2F, 8'h5E, 8'hBC, 8'h78, 8'hF1, 8'hE3};
        logic [7:0] exp [16];
        logic       prev;
        int         n, idx, zbad, guard;
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < 8; c++) begin
                case (p)
                    2'd0: exp[l*8+c] = 8'(c);
                    2'd1: exp[l*8+c] = c[0] ? 8'hAA : 8'h55;
                    2'd2: exp[l*8+c] = 8'(l);
                    default: exp[l*8+c] = prbs_tab[l*8+c];
                endcase
            end
        end
        pattern_sel = p;
        step();
        run_len(2, 1'b0, n);
        pattern_sel = p ^ 2'd1;
        idx = 0;
        zbad = 0;
        guard = 0;
        prev = dvp_pclk;
        step();
        while (frame_done !== 1'b1 && guard < 400) begin
            if (dvp_pclk && !prev && dvp_href) begin
                if (idx < 16) begin
                    n_cmp++;
                    if (dvp_data !== exp[idx]) begin
                        n_bad++;
                        $display("FAIL data_p%0d[%0d]: got %h want %h",
                                 p, idx, dvp_data, exp[idx]);
                    end
                end
                idx++;
            end
            if (!dvp_href && dvp_data !== 8'h00) zbad++;
            prev = dvp_pclk;
            guard++;
            step();
        end
        n_cmp++;
        if (idx !== 16 || zbad !== 0) begin
            n_bad++;
            $display("FAIL data_p%0d_count: bytes %0d nonzero-idle %0d want 16 0",
                     p, idx, zbad);
        end
    endtask

    task automatic test_crc();
        logic [15:0] want;
        int n;
`ifdef OV_DVP_GEN_CRC_EN
        want = 16'hFFFF;
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 8; c++)
                want = crc16(want, 8'(c));
`else
        want = 16'h0000;
`endif
        pattern_sel = 2'd0;
        step();
        run_len(2, 1'b0, n);
        for (int f = 0; f < 2; f++) begin
            step();
            run_len(2, 1'b0, n);
            n_cmp++;
            if (frame_crc !== want) begin
                n_bad++;
                $display("FAIL frame_crc[%0d]: got %h want %h",
                         f, frame_crc, want);
            end
        end
    endtask

    task automatic test_stop();
        logic [15:0] cnt0;
        logic        prev;
        int          n, rises, dones, busies;
        run_len(1, 1'b0, n);
        n_cmp++;
        if (dvp_href !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_wait_href: got %b want 1", dvp_href);
        end
        enable = 1'b0;
        cnt0 = frame_cnt;
        run_len(2, 1'b0, n);
        n_cmp++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'(cnt0 + 1)) begin
            n_bad++;
            $display("FAIL stop_done: done %b cnt %h want 1 %h",
                     frame_done, frame_cnt, 16'(cnt0 + 1));
        end
        n_cmp++;
        if ({busy, dvp_vsync, dvp_href, dvp_data} !== 11'd0) begin
            n_bad++;
            $display("FAIL stop_idle: busy %b vs %b hr %b data %h want 0",
                     busy, dvp_vsync, dvp_href, dvp_data);
        end
        rises = 0;
        dones = 0;
        busies = 0;
        prev = dvp_pclk;
        for (int i = 0; i < 300; i++) begin
            step();
            if (dvp_pclk && !prev) rises++;
            if (frame_done) dones++;
            if (busy) busies++;
            prev = dvp_pclk;
        end
        n_cmp++;
        if (rises !== 75 || dones !== 0 || busies !== 0) begin
            n_bad++;
            $display("FAIL stop_after: rises %0d done %0d busy %0d want 75 0 0",
                     rises, dones, busies);
        end
    endtask

    task automatic test_wrap();
        int n;
        enable = 1'b1;
        run_len(0, 1'b0, n);
        n_cmp++;
        if (n > 4) begin
            n_bad++;
            $display("FAIL wrap_start: got %0d cycles want <=4", n);
        end
        force dut.frame_cnt = 16'hFFFF;
        step();
        step();
        release dut.frame_cnt;
        run_len(2, 1'b0, n);
        n_cmp++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL cnt_wrap: done %b cnt %h want 1 0000",
                     frame_done, frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        run_len(1, 1'b0, n);
        n_cmp++;
        if (dvp_href !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_wait_href: got %b want 1", dvp_href);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dvp_vsync, dvp_href, dvp_data, busy, frame_cnt} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_mid: vs %b hr %b data %h busy %b cnt %h want 0",
                     dvp_vsync, dvp_href, dvp_data, busy, frame_cnt);
        end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_framing();
        test_data(2'd0);
        test_data(2'd1);
        test_data(2'd2);
        test_data(2'd3);
        test_crc();
        test_stop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
